serial_pattern_tx: RTL and testbench

Serial pattern transmitter that produces the bit streams our sequence detectors consume. It is the stimulus/transmit side of the serial-detect path.
- Captures a parallel pattern, a length, a repeat count and an inter-repeat gap on a start handshake.
- Shifts the pattern out MSB-first, one bit per clk, with a valid qualifier.
- Pulses done when the whole burst has been sent.

---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_pattern_tx_if.sv | 39 +++
 rtl/tx_down_counter.sv | 47 ++++
 rtl/serial_pattern_tx.sv | 167 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and size defaults for the serial-detect path
//
// Purpose: one place for the transmitter FSM encoding and the default sizes,
// so the detector benches and the transmitter agree on widths.
// Ports: none (package).

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - burst request and serial output bundle of serial_pattern_tx
//
// Purpose: groups the start/abort request, burst description and serial
// output of the pattern transmitter.
// Ports (signals):
//   start, abort                 request / abort of a burst (master -> slave)
//   pattern, len, rep, gap       burst description (master -> slave)
//   sout, sout_valid, busy, done serial data and status (slave -> master)

interface serial_pattern_tx_if
  import serial_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   rep;
  logic [CNT_W-1:0]   gap;
  logic               sout;
  logic               sout_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, pattern, len, rep, gap,
    input  sout, sout_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, rep, gap,
    output sout, sout_valid, busy, done
  );

endinterface

// File: rtl/tx_down_counter.sv
// rtl/tx_down_counter.sv - loadable saturating down counter with zero flag
//
// Purpose: counts down from a loaded value and stops at zero.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load_i         load load_val_i (has priority over dec_i)
//   load_val_i     value to load
//   dec_i          decrement by one; ignored when the count is already zero
//   cnt_o          current count
//   zero_o         count equals zero

module tx_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serial pattern transmitter feeding the sequence detectors
//
// Purpose: captures a pattern/len/rep/gap on start and shifts the pattern out
// MSB-first (bit L-1 first), rep+1 times with gap idle cycles in between,
// then pulses done. All outputs are registered.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  start/abort/pattern/len/rep/gap in; sout/sout_valid/busy/done out

module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int   MAX_LEN  = DEF_MAX_LEN,
  parameter int   LEN_W    = $clog2(MAX_LEN) + 1,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter logic IDLE_LVL = 1'b0
) (
  input logic               clk,
  input logic               reset,
  serial_pattern_tx_if.slave bus
);

  tx_state_e          state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   lm1_q;     // captured effective length minus one
  logic [CNT_W-1:0]   gap_q;

  logic sout_q, sout_d;
  logic sout_valid_q, sout_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [LEN_W-1:0]   eff_len, eff_lm1;
  logic               cap;
  logic               bit_load, bit_dec, rep_load, rep_dec, gap_load, gap_dec;
  logic [LEN_W-1:0]   bit_load_val, nxt_idx, idx_cnt;
  logic               idx_zero, rep_zero, gap_zero;
  logic [CNT_W-1:0]   rep_cnt, gap_cnt;
  logic [MAX_LEN-1:0] pat_src, pat_shift;
  logic               unused_cnt_bits;

  assign eff_len = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
  assign eff_lm1 = eff_len - LEN_W'(1);

  // In IDLE the burst is not captured yet, so the first bit comes from the inputs.
  assign bit_load_val = (state_q == IDLE) ? eff_lm1 : lm1_q;
  assign pat_src      = (state_q == IDLE) ? bus.pattern : pattern_q;

  tx_down_counter #(.W(LEN_W)) u_bit_cnt (
    .clk(clk), .reset(reset), .load_i(bit_load), .load_val_i(bit_load_val),
    .dec_i(bit_dec), .cnt_o(idx_cnt), .zero_o(idx_zero)
  );

  tx_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk(clk), .reset(reset), .load_i(rep_load), .load_val_i(bus.rep),
    .dec_i(rep_dec), .cnt_o(rep_cnt), .zero_o(rep_zero)
  );

  // Loaded with gap-1 so that the GAP state lasts exactly gap cycles.
  tx_down_counter #(.W(CNT_W)) u_gap_cnt (
    .clk(clk), .reset(reset), .load_i(gap_load), .load_val_i(gap_q - CNT_W'(1)),
    .dec_i(gap_dec), .cnt_o(gap_cnt), .zero_o(gap_zero)
  );

  assign unused_cnt_bits = ^{rep_cnt, gap_cnt};

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pattern_q    <= '0;
      lm1_q        <= '0;
      gap_q        <= '0;
      sout_q       <= IDLE_LVL;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (cap) begin
        pattern_q <= bus.pattern;
        lm1_q     <= eff_lm1;
        gap_q     <= bus.gap;
      end
    end
  end

  // Next-state and counter control; nxt_idx is the bit index shown next cycle.
  always_comb begin
    state_d  = state_q;
    cap      = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    nxt_idx  = idx_cnt;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cap      = 1'b1;
          rep_load = 1'b1;
          if (eff_len == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SHIFT;
            bit_load = 1'b1;
            nxt_idx  = eff_lm1;
          end
        end
      end
      SHIFT: begin
        if (!idx_zero) begin
          bit_dec = 1'b1;
          nxt_idx = idx_cnt - LEN_W'(1);
        end else if (rep_zero) begin
          state_d = DONE;
        end else begin
          rep_dec = 1'b1;
          if (gap_q == '0) begin
            bit_load = 1'b1;
            nxt_idx  = lm1_q;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d  = SHIFT;
          bit_load = 1'b1;
          nxt_idx  = lm1_q;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    pat_shift    = pat_src >> nxt_idx;
    sout_valid_d = (state_d == SHIFT);
    sout_d       = sout_valid_d ? pat_shift[0] : IDLE_LVL;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx

module tb_serial_pattern_tx;

  localparam int DONE_MARK = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  serial_pattern_tx_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) bus ();

  serial_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .IDLE_LVL(1'b0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(int'(bits[i]));
  endtask

  task automatic push_done();
    exp_q.push_back(DONE_MARK);
  endtask

  task automatic start_burst(input logic [7:0] pat, input logic [3:0] len,
                             input logic [3:0] rep, input logic [3:0] gap);
    bus.pattern = pat;
    bus.len     = len;
    bus.rep     = rep;
    bus.gap     = gap;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.sout_valid) begin
          if (exp_q.size() == 0) check("unexpected_bit", 32'(bus.sout), 32'hDEAD);
          else begin
            e = exp_q.pop_front();
            check("sout_bit", 32'(bus.sout), e);
          end
        end else begin
          check("idle_level", 32'(bus.sout), 0);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) check("unexpected_done", 32'(bus.done), 0);
          else begin
            e = exp_q.pop_front();
            check("done_order", DONE_MARK, e);
          end
        end
      end
    end
  endtask

  task automatic single_test();
    push_seq(32'b1101, 4);
    push_done();
    start_burst(8'b0000_1101, 4'd4, 4'd0, 4'd0);
    check("single_first_valid", 32'(bus.sout_valid), 1);
    check("single_first_bit", 32'(bus.sout), 1);
    repeat (3) tick();
    check("single_c4_valid", 32'(bus.sout_valid), 1);
    tick();
    check("single_c5_done", 32'(bus.done), 1);
    check("single_c5_valid", 32'(bus.sout_valid), 0);
    tick();
    check("single_c6_busy", 32'(bus.busy), 0);
    check("single_c6_done", 32'(bus.done), 0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rep     = '0;
    bus.gap     = '0;
    fork
      monitor();
    join_none
    repeat (2) tick();
    check("rst_sout", 32'(bus.sout), 0);
    check("rst_valid", 32'(bus.sout_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    tick();

    single_test();
    tick();

    // back-to-back repeat, no gap
    push_seq(32'b101010, 6);
    push_done();
    start_burst(8'b0000_0010, 4'd2, 4'd2, 4'd0);
    for (int c = 0; c < 6; c++) begin
      check("b2b_valid", 32'(bus.sout_valid), 1);
      tick();
    end
    check("b2b_done", 32'(bus.done), 1);
    tick();

    // repeat with gap of 3
    push_seq(32'b1101, 4);
    push_seq(32'b1101, 4);
    push_done();
    start_burst(8'b0000_1101, 4'd4, 4'd1, 4'd3);
    for (int c = 1; c <= 12; c++) begin
      check("gap_valid", 32'(bus.sout_valid), 32'((c <= 4) || (c >= 8 && c <= 11)));
      check("gap_busy", 32'(bus.busy), 1);
      check("gap_done", 32'(bus.done), 32'(c == 12));
      tick();
    end
    check("gap_end_busy", 32'(bus.busy), 0);
    tick();

    // len = 0: done only
    push_done();
    start_burst(8'hFF, 4'd0, 4'd3, 4'd2);
    check("len0_done", 32'(bus.done), 1);
    check("len0_valid", 32'(bus.sout_valid), 0);
    tick();
    check("len0_busy", 32'(bus.busy), 0);
    tick();

    // len = 15 clamps to 8 bits
    push_seq(32'hA5, 8);
    push_done();
    start_burst(8'hA5, 4'd15, 4'd0, 4'd0);
    repeat (8) tick();
    check("len15_done", 32'(bus.done), 1);
    tick();
    check("len15_busy", 32'(bus.busy), 0);
    tick();

    // start during burst ignored, abort in GAP with start
    push_seq(32'b1101, 4);
    start_burst(8'b0000_1101, 4'd4, 4'd1, 4'd3);
    tick();
    bus.pattern = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    repeat (2) tick();
    check("abort_in_gap_valid", 32'(bus.sout_valid), 0);
    check("abort_in_gap_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_valid", 32'(bus.sout_valid), 0);
    check("abort_done", 32'(bus.done), 0);
    tick();
    check("abort_stays_idle", 32'(bus.busy), 0);
    tick();

    // reset at 2nd bit of repetition 2
    push_seq(32'b11011, 5);
    start_burst(8'b0000_1101, 4'd4, 4'd3, 4'd0);
    repeat (5) tick();
    #1 reset = 1'b1;
    #1;
    check("midrst_sout", 32'(bus.sout), 0);
    check("midrst_valid", 32'(bus.sout_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("postrst_busy", 32'(bus.busy), 0);
    single_test();

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
